axi_stream_rr_arbiter: RTL and testbench
========================================

Name: axi_stream_rr_arbiter

Overview:
- N-to-1 AXI4-Stream arbiter: shares one downstream slave between N upstream masters.
- Round-robin grant with packet lock: a granted master keeps the output until its tlast beat is accepted.
- Sits between several axi_stream_master instances and one axi_stream_slave. Datapath is combinational pass-through of the granted port; control is registered.

Parameters:
- NUM_PORTS, 4, number of upstream masters (2..16).
- IDX_W, $clog2(NUM_PORTS), width of the grant index (derived; not overridden).

Ports:
- aclk  in  1  clock.
- areset_n  in  1  reset; synchronous, active-low.
- s_tvalid  in  NUM_PORTS  per-master valid.
- s_tready  out  NUM_PORTS  per-master ready.
- s_tdata  in  NUM_PORTS x data_t  per-master data (unpacked array).
- s_tlast  in  NUM_PORTS  per-master last.
- m_tvalid  out  1  downstream valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  data_t  downstream data.
- m_tlast  out  1  downstream last.
- grant_valid  out  1  a port is currently locked.
- grant_idx  out  IDX_W  currently locked port.

Behaviour:
- Reset (areset_n low at a rising aclk edge): state=IDLE, grant_idx=0, rr_ptr=0, grant_valid=0. Outputs while IDLE: m_tvalid=0, m_tlast=0, s_tready=0. m_tdata is don't-care but driven to 0.
- States: IDLE, LOCKED (arb_state_t).
- IDLE:
  - If any s_tvalid is set, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., N-1, 0, ...).
  - Next cycle: state=LOCKED, grant_idx=selected, grant_valid=1.
  - With no request, stay IDLE.
  - Arbitration latency: exactly 1 cycle from request to m_tvalid; no beat is transferred in the IDLE cycle.
- LOCKED (g=grant_idx):
  - m_tvalid=s_tvalid[g], m_tdata=s_tdata[g], m_tlast=s_tlast[g], s_tready[g]=m_tready. All other s_tready are 0.
  - Handshake is m_tvalid&&m_tready. On a handshake with m_tlast=1: next state=IDLE, rr_ptr=(g+1) mod NUM_PORTS, grant_valid=0.
  - A non-last handshake or no handshake keeps LOCKED.
  - Valid deasserting mid-packet holds the lock; there is no timeout.
- Fairness: back-to-back packets from different masters have one IDLE bubble between them. A master just served has lowest priority next round.
- Single requester: that master is granted regardless of rr_ptr. The wrap search covers all ports.
- Simultaneous tlast accept and new requests: the new grant is decided in the following IDLE cycle, using the updated rr_ptr.
- Reset mid-packet: lock dropped immediately; the partial packet is abandoned (no tlast issued). Upstream must restart.
- Masters never see tready without a grant; AXI rule "valid must not depend on ready" is preserved.
- rr_ptr wrap: for NUM_PORTS not a power of two, the increment wraps explicitly at NUM_PORTS-1 to 0.

Optional Feature:
- Macro AXIS_ARB_PKT_CNT_EN.
- Defined: adds output pkt_cnt [NUM_PORTS] x 16 bits, one counter per port. A counter increments on each accepted tlast beat from its port, saturates at 16'hffff, and resets to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Add to axi_stream_pkg:
  - arb_state_t enum {IDLE, LOCKED}.
  - constant AXIS_ARB_CNT_W = 16.
  - reuse existing data_t (32-bit).
- Sub-module rr_pick: combinational.
  - Inputs: req[NUM_PORTS], ptr[IDX_W].
  - Outputs: any, idx[IDX_W].
  - Returns the first set bit at or after ptr with wrap. Instantiated once in the arbiter.

Test Plan:
- Reset then single master 0 sends 8 beats 32'hdeadbeef..+7, last on beat 7, m_tready=1 -> m_tvalid first high 1 cycle after s_tvalid; slave receives deadbeef..deadbef6 in order; grant_valid falls after beat 7.
- Masters 0..3 all request 2-beat packets continuously, NUM_PORTS=4 -> grant order 0,1,2,3,0; one IDLE cycle between packets; no interleaving within a packet.
- Lock hold: master 1 drops s_tvalid for 3 cycles mid-packet while master 2 requests -> grant_idx stays 1; master 2 is granted only after master 1's tlast.
- Backpressure: m_tready toggles 1010... during a 4-beat packet -> each beat delivered exactly once; s_tready[g] mirrors m_tready; non-granted s_tready=0.
- Reset mid-packet: areset_n low after beat 2 of 5 -> next cycle m_tvalid=0, grant_valid=0, rr_ptr=0; the next request from master 3 alone is granted.
- With AXIS_ARB_PKT_CNT_EN defined: master 2 sends 3 packets -> pkt_cnt[2]=3, all others 0.

Source files
------------

// File: rtl/axi_stream_pkg.sv
// axi_stream_pkg: shared AXI4-Stream types and arbiter constants.
//   data_t          32-bit stream payload
//   arb_state_t     arbiter lock state (IDLE, LOCKED)
//   AXIS_ARB_CNT_W  width of the optional per-port packet counters
package axi_stream_pkg;
  typedef logic [31:0] data_t;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  localparam int AXIS_ARB_CNT_W = 16;
endpackage

// File: rtl/axi_stream_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  in   NUM_PORTS  request vector
//   ptr  in   IDX_W      highest-priority position
//   any  out  1          at least one request present
//   idx  out  IDX_W      first set bit at or after ptr, wrapping past NUM_PORTS-1
module rr_pick #(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 any,
  output logic [IDX_W-1:0]     idx
);
  // Scan offsets from farthest to nearest so the nearest request from ptr wins.
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NUM_PORTS]) idx = IDX_W'((int'(ptr) + k) % NUM_PORTS);
  end
endmodule

// File: rtl/axi_stream_rr_arbiter.sv
// axi_stream_rr_arbiter: N-to-1 AXI4-Stream round-robin arbiter with packet lock.
//   aclk, areset_n           clock, synchronous active-low reset
//   s_tvalid/s_tready/s_tdata/s_tlast   upstream masters (NUM_PORTS wide)
//   m_tvalid/m_tready/m_tdata/m_tlast   downstream slave
//   grant_valid, grant_idx   current lock status and locked port
//   pkt_cnt                  per-port accepted packet counters, saturating
//                            (present only when AXIS_ARB_PKT_CNT_EN is defined)
module axi_stream_rr_arbiter
  import axi_stream_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  input  logic [NUM_PORTS-1:0] s_tvalid,
  output logic [NUM_PORTS-1:0] s_tready,
  input  data_t                s_tdata [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output data_t                m_tdata,
  output logic                 m_tlast,
  output logic                 grant_valid,
`ifdef AXIS_ARB_PKT_CNT_EN
  output logic [IDX_W-1:0]     grant_idx,
  output logic [AXIS_ARB_CNT_W-1:0] pkt_cnt [NUM_PORTS]
`else
  output logic [IDX_W-1:0]     grant_idx
`endif
);
  arb_state_t state, state_n;
  logic [IDX_W-1:0] grant_idx_n, rr_ptr, rr_ptr_n, pick_idx;
  logic pick_any, locked, last_acc;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req(s_tvalid),
    .ptr(rr_ptr),
    .any(pick_any),
    .idx(pick_idx)
  );

  assign locked = state == LOCKED;
  assign grant_valid = locked;

  // The grant is decided in IDLE and only takes effect next cycle, so no beat
  // moves during the arbitration cycle and tready never reaches an ungranted port.
  always_comb begin
    m_tvalid = locked & s_tvalid[grant_idx];
    m_tdata = locked ? s_tdata[grant_idx] : '0;
    m_tlast = locked & s_tlast[grant_idx];
    s_tready = '0;
    s_tready[grant_idx] = locked & m_tready;
    last_acc = m_tvalid & m_tready & m_tlast;
    state_n = state;
    grant_idx_n = grant_idx;
    rr_ptr_n = rr_ptr;
    if (!locked && pick_any) begin
      state_n = LOCKED;
      grant_idx_n = pick_idx;
    end
    if (last_acc) begin
      state_n = IDLE;
      rr_ptr_n = grant_idx == IDX_W'(NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state <= IDLE;
      grant_idx <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      grant_idx <= grant_idx_n;
      rr_ptr <= rr_ptr_n;
    end
  end

`ifdef AXIS_ARB_PKT_CNT_EN
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NUM_PORTS; i++)
      if (!areset_n) pkt_cnt[i] <= '0;
      else if (last_acc && grant_idx == IDX_W'(i) && pkt_cnt[i] != '1) pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
  end
`else
`endif
endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// tb_axi_stream_rr_arbiter: randomized self-checking bench for axi_stream_rr_arbiter.
module tb_axi_stream_rr_arbiter;
  import axi_stream_pkg::*;
  localparam int NP = 4;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic areset_n, m_tvalid, m_tready, m_tlast, grant_valid;
  logic [NP-1:0] s_tvalid, s_tready, s_tlast;
  data_t s_tdata [NP];
  data_t m_tdata;
  logic [1:0] grant_idx;

  axi_stream_rr_arbiter #(.NUM_PORTS(NP)) dut (
    .aclk(aclk),
    .areset_n(areset_n),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata(s_tdata),
    .s_tlast(s_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata(m_tdata),
    .m_tlast(m_tlast),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx)
  );

  typedef struct {data_t d; logic l; logic b;} beat_t;
  typedef struct {int p; data_t d; logic l;} rx_t;

  beat_t q [NP][$];
  data_t sent [NP][$];
  bit held [NP];
  rx_t rx [$];
  int own, prio, mgi, vprob, tr_mode, tr_ph, asserts, fails;
  logic [40:0] obs, expv;

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) if (q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send(int p, data_t base, int len, int gap_at, int gap_len);
    for (int i = 0; i < len; i++) begin
      if (i == gap_at) for (int g = 0; g < gap_len; g++) q[p].push_back('{d: '0, l: 1'b0, b: 1'b1});
      q[p].push_back('{d: base + data_t'(i), l: (i == len - 1), b: 1'b0});
      sent[p].push_back(base + data_t'(i));
    end
  endtask

  // One clock: drive masters, sample at negedge, predict from the arbitration
  // rules, then advance masters and the reference model after the edge.
  task automatic tick();
    logic e_mv, e_ml;
    data_t e_md;
    logic [NP-1:0] e_rdy;
    for (int p = 0; p < NP; p++) begin
      if (q[p].size() == 0 || q[p][0].b) begin
        s_tvalid[p] = 1'b0;
        s_tdata[p] = $urandom;
        s_tlast[p] = 1'b0;
      end else begin
        if (!held[p]) held[p] = $urandom_range(99) < vprob;
        s_tvalid[p] = held[p];
        s_tdata[p] = held[p] ? q[p][0].d : $urandom;
        s_tlast[p] = held[p] ? q[p][0].l : 1'b0;
      end
    end
    m_tready = tr_mode == 0 ? 1'b1 : tr_mode == 1 ? (tr_ph % 2 == 0) : 1'($urandom_range(1));
    @(negedge aclk);
    e_mv = 1'b0;
    e_ml = 1'b0;
    e_md = '0;
    e_rdy = '0;
    if (own >= 0) begin
      e_mv = s_tvalid[own];
      e_ml = s_tlast[own];
      e_md = s_tdata[own];
      e_rdy[own] = m_tready;
    end
    expv = {e_mv, e_ml, own >= 0, 2'(mgi), e_rdy, e_md};
    obs = {m_tvalid, m_tlast, grant_valid, grant_idx, s_tready, m_tdata};
    @(posedge aclk);
    #1;
    if (areset_n && obs[40] && m_tready) rx.push_back('{int'(obs[37:36]), obs[31:0], obs[39]});
    for (int p = 0; p < NP; p++)
      if (q[p].size() != 0) begin
        if (q[p][0].b) void'(q[p].pop_front());
        else if (s_tvalid[p] && obs[32 + p]) begin
          void'(q[p].pop_front());
          held[p] = 1'b0;
        end
      end
    if (!areset_n) begin
      own = -1;
      prio = 0;
      mgi = 0;
    end else if (own < 0) begin
      for (int i = 0; i < NP; i++)
        if (own < 0 && s_tvalid[(prio + i) % NP]) own = (prio + i) % NP;
      if (own >= 0) mgi = own;
    end else if (s_tvalid[own] && m_tready && s_tlast[own]) begin
      prio = (own + 1) % NP;
      own = -1;
    end
    tr_ph++;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    for (int p = 0; p < NP; p++) begin
      q[p].delete();
      sent[p].delete();
      held[p] = 1'b0;
    end
    rx.delete();
    tick();
    tick();
    areset_n = 1'b1;
  endtask

  task automatic test_reset();
    vprob = 100;
    tr_mode = 0;
    areset_n = 1'b0;
    for (int p = 0; p < NP; p++) send(p, 32'hA000_0000 + data_t'(p), 2, -1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      asserts++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL reset_cycle t=%0t got=%h exp=%h", $time, obs, expv);
      end
      asserts++;
      if (obs !== 41'd0) begin
        fails++;
        $display("FAIL reset_idle_outputs t=%0t got=%h exp=0", $time, obs);
      end
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    send(0, 32'hdeadbeef, 8, -1, 0);
    n = 0;
    while (!all_empty() && n < 50) begin
      tick();
      n++;
      asserts++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL single_cycle t=%0t got=%h exp=%h", $time, obs, expv);
      end
    end
    asserts++;
    if (n !== 9) begin
      fails++;
      $display("FAIL single_latency got=%0d cycles exp=9", n);
    end
    tick();
    asserts++;
    if (obs[38] !== 1'b0 || obs !== expv) begin
      fails++;
      $display("FAIL single_release got=%h exp=%h", obs, expv);
    end
    asserts++;
    if (rx.size() !== 8) begin
      fails++;
      $display("FAIL single_count got=%0d exp=8", rx.size());
    end else
      for (int i = 0; i < 8; i++) begin
        asserts++;
        if (rx[i].d !== 32'hdeadbeef + data_t'(i) || rx[i].p !== 0 || rx[i].l !== (i == 7)) begin
          fails++;
          $display("FAIL single_beat%0d got=%h/%0d/%b exp=%h/0/%b", i, rx[i].d, rx[i].p, rx[i].l,
                   32'hdeadbeef + data_t'(i), i == 7);
        end
      end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) send(p, 32'h1000_0000 * data_t'(p + 1) + data_t'(k * 256), 2, -1, 0);
    n = 0;
    while (!all_empty() && n < 100) begin
      tick();
      n++;
      asserts++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL rr_cycle t=%0t got=%h exp=%h", $time, obs, expv);
      end
    end
    asserts++;
    if (n !== 24) begin
      fails++;
      $display("FAIL rr_cycles got=%0d exp=24", n);
    end
    asserts++;
    if (rx.size() !== 16) begin
      fails++;
      $display("FAIL rr_count got=%0d exp=16", rx.size());
    end else
      for (int k = 0; k < 8; k++) begin
        asserts++;
        if (rx[2 * k].p !== k % NP || rx[2 * k + 1].p !== k % NP || rx[2 * k + 1].l !== 1'b1) begin
          fails++;
          $display("FAIL rr_order pkt%0d got=%0d,%0d exp=%0d", k, rx[2 * k].p, rx[2 * k + 1].p, k % NP);
        end
      end
  endtask

  task automatic test_lock_hold();
    int n;
    do_reset();
    send(1, 32'h0000_1100, 4, 2, 3);
    send(2, 32'h0000_2200, 2, -1, 0);
    n = 0;
    while (!all_empty() && n < 60) begin
      tick();
      n++;
      asserts++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL lock_cycle t=%0t got=%h exp=%h", $time, obs, expv);
      end
    end
    asserts++;
    if (n !== 11) begin
      fails++;
      $display("FAIL lock_cycles got=%0d exp=11", n);
    end
    asserts++;
    if (rx.size() !== 6) begin
      fails++;
      $display("FAIL lock_count got=%0d exp=6", rx.size());
    end else
      for (int i = 0; i < 6; i++) begin
        asserts++;
        if (rx[i].p !== (i < 4 ? 1 : 2)) begin
          fails++;
          $display("FAIL lock_order beat%0d got=%0d exp=%0d", i, rx[i].p, i < 4 ? 1 : 2);
        end
      end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    tr_mode = 1;
    tr_ph = 0;
    send(3, 32'h3300_0000, 4, -1, 0);
    n = 0;
    while (!all_empty() && n < 60) begin
      tick();
      n++;
      asserts++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL bp_cycle t=%0t got=%h exp=%h", $time, obs, expv);
      end
    end
    tr_mode = 0;
    asserts++;
    if (n !== 9) begin
      fails++;
      $display("FAIL bp_cycles got=%0d exp=9", n);
    end
    asserts++;
    if (rx.size() !== 4) begin
      fails++;
      $display("FAIL bp_count got=%0d exp=4", rx.size());
    end else
      for (int i = 0; i < 4; i++) begin
        asserts++;
        if (rx[i].d !== 32'h3300_0000 + data_t'(i) || rx[i].p !== 3) begin
          fails++;
          $display("FAIL bp_beat%0d got=%h/%0d exp=%h/3", i, rx[i].d, rx[i].p, 32'h3300_0000 + data_t'(i));
        end
      end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    send(1, 32'h0000_0001, 1, -1, 0);
    for (int i = 0; i < 3; i++) tick();
    rx.delete();
    send(2, 32'h0000_2000, 5, -1, 0);
    n = 0;
    while (rx.size() < 2 && n < 20) begin
      tick();
      n++;
      asserts++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL mid_cycle t=%0t got=%h exp=%h", $time, obs, expv);
      end
    end
    asserts++;
    if (rx.size() !== 2) begin
      fails++;
      $display("FAIL mid_timeout got=%0d beats exp=2", rx.size());
    end
    areset_n = 1'b0;
    tick();
    areset_n = 1'b1;
    q[2].delete();
    held[2] = 1'b0;
    tick();
    asserts++;
    if (obs[40] !== 1'b0 || obs[38] !== 1'b0 || obs !== expv) begin
      fails++;
      $display("FAIL mid_dropped got=%h exp=%h", obs, expv);
    end
    rx.delete();
    send(1, 32'h0000_0010, 1, -1, 0);
    send(3, 32'h0000_0030, 1, -1, 0);
    n = 0;
    while (!all_empty() && n < 30) begin
      tick();
      n++;
      asserts++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL mid_after t=%0t got=%h exp=%h", $time, obs, expv);
      end
    end
    send(3, 32'h0000_0031, 1, -1, 0);
    n = 0;
    while (!all_empty() && n < 30) begin
      tick();
      n++;
      asserts++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL mid_alone t=%0t got=%h exp=%h", $time, obs, expv);
      end
    end
    asserts++;
    if (rx.size() !== 3 || rx[0].p !== 1 || rx[1].p !== 3 || rx[2].p !== 3) begin
      fails++;
      $display("FAIL mid_order got size=%0d ports=%0d,%0d,%0d exp 3 ports=1,3,3", rx.size(),
               rx.size() > 0 ? rx[0].p : -1, rx.size() > 1 ? rx[1].p : -1, rx.size() > 2 ? rx[2].p : -1);
    end
  endtask

  task automatic test_random();
    int n, p, len;
    int idx [NP];
    do_reset();
    vprob = 60;
    tr_mode = 2;
    for (int k = 0; k < 30; k++) begin
      p = $urandom_range(NP - 1);
      len = $urandom_range(1, 4);
      send(p, $urandom, len, $urandom_range(0, len), $urandom_range(0, 2));
    end
    n = 0;
    while (!all_empty() && n < 3000) begin
      tick();
      n++;
      asserts++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL rand_cycle t=%0t got=%h exp=%h", $time, obs, expv);
      end
    end
    asserts++;
    if (!all_empty()) begin
      fails++;
      $display("FAIL rand_timeout got=%0d cycles exp<3000", n);
    end
    for (int i = 0; i < NP; i++) idx[i] = 0;
    foreach (rx[i]) begin
      p = rx[i].p;
      asserts++;
      if (p < 0 || p >= NP || idx[p] >= sent[p].size() || rx[i].d !== sent[p][idx[p]]) begin
        fails++;
        $display("FAIL rand_data beat%0d port=%0d got=%h", i, p, rx[i].d);
      end else idx[p]++;
    end
    for (int i = 0; i < NP; i++) begin
      asserts++;
      if (idx[i] !== sent[i].size()) begin
        fails++;
        $display("FAIL rand_count port%0d got=%0d exp=%0d", i, idx[i], sent[i].size());
      end
    end
    vprob = 100;
    tr_mode = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    asserts = 0;
    fails = 0;
    own = -1;
    prio = 0;
    mgi = 0;
    tr_ph = 0;
    vprob = 100;
    tr_mode = 0;
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tlast = '0;
    for (int p = 0; p < NP; p++) begin
      s_tdata[p] = '0;
      held[p] = 1'b0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_lock_hold();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
